// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR bank: per-channel FSM states, the
// XAPP052 tap-mask table and the channel-select width derivation.
package lfsr_pkg;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } lfsr_state_e;

  // Channel-select width: at least one bit even for a single channel.
  function automatic int unsigned lfsr_chw(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic logic [31:0] tap_bit(input int unsigned n);
    return 32'h1 << (n - 1);
  endfunction

  // XAPP052 XNOR feedback taps, bit n of the table maps to mask bit n-1.
  function automatic logic [31:0] lfsr_taps(input int unsigned dsize);
    logic [31:0] m;
    m = '0;
    case (dsize)
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_chan.sv
// One LFSR channel: state register, STEPS-unrolled XNOR step, warm-up
// counter and WARM/RUN FSM.
//   clk_i, reset_i : clock, synchronous active-high reset
//   adv_i          : advance request (honoured in RUN only)
//   load_i         : seed load strobe, beats any advance
//   load_dat_i     : seed value, already cleaned of the all-ones state
//   dat_o          : registered LFSR state
//   vld_o          : channel is in RUN
module lfsr_chan
  import lfsr_pkg::*;
#(
  parameter int unsigned       DSIZE    = 16,
  parameter int unsigned       STEPS    = 1,
  parameter int unsigned       WARMUP   = 8,
  parameter logic [DSIZE-1:0]  RST_SEED = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             adv_i,
  input  logic             load_i,
  input  logic [DSIZE-1:0] load_dat_i,
  output logic [DSIZE-1:0] dat_o,
  output logic             vld_o
);

  localparam int unsigned      CW        = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0]    WARM_INIT = CW'(WARMUP);
  localparam lfsr_state_e      START_ST  = (WARMUP == 0) ? RUN : WARM;
  localparam logic [DSIZE-1:0] TAPS      = DSIZE'(lfsr_taps(DSIZE));

  lfsr_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DSIZE-1:0] lfsr_q, lfsr_d, adv_val;

  // XNOR of the tap bits enters at bit 0; masked-off bits contribute nothing.
  function automatic logic [DSIZE-1:0] step(input logic [DSIZE-1:0] s);
    return {s[DSIZE-2:0], ~^(s & TAPS)};
  endfunction

  always_comb begin
    adv_val = lfsr_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv_val = step(adv_val);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    if (load_i) begin
      lfsr_d  = load_dat_i;
      cnt_d   = WARM_INIT;
      state_d = START_ST;
    end else begin
      case (state_q)
        WARM: begin
          lfsr_d = adv_val;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (adv_i) begin
            lfsr_d = adv_val;
          end
        end
        default: state_d = START_ST;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= START_ST;
      cnt_q   <= WARM_INIT;
      lfsr_q  <= RST_SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign dat_o = lfsr_q;
  assign vld_o = (state_q == RUN);

endmodule

// File: rtl/lfsr_bank.sv
// Bank of NUM_CH independent XNOR Fibonacci LFSRs with seed loading,
// leap-forward advance, all-ones protection and per-channel warm-up.
//   clk_i, reset_i : clock, synchronous active-high reset
//   rd_rand_i      : per-channel advance request
//   seed_we_i      : seed write strobe
//   seed_ch_i      : target channel (out-of-range writes are dropped)
//   seed_dat_i     : seed value
//   lfsr_dat_o     : channel c at [c*DSIZE +: DSIZE], registered
//   lfsr_vld_o     : per-channel RUN flag
//   seed_err_o     : one-cycle pulse when an all-ones seed was replaced by 0
module lfsr_bank
  import lfsr_pkg::*;
#(
  parameter  int unsigned DSIZE  = 16,
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned STEPS  = 1,
  parameter  int unsigned SEED   = 2,
  parameter  int unsigned WARMUP = 8,
  localparam int unsigned CHW    = lfsr_chw(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_CH-1:0]       rd_rand_i,
  input  logic                    seed_we_i,
  input  logic [CHW-1:0]          seed_ch_i,
  input  logic [DSIZE-1:0]        seed_dat_i,
  output logic [NUM_CH*DSIZE-1:0] lfsr_dat_o,
  output logic [NUM_CH-1:0]       lfsr_vld_o,
  output logic                    seed_err_o
);

  logic             seed_hit;
  logic             seed_ones;
  logic [DSIZE-1:0] seed_clean;
  logic             seed_err_q;

  assign seed_hit   = seed_we_i && (32'(seed_ch_i) < NUM_CH);
  assign seed_ones  = &seed_dat_i;
  assign seed_clean = seed_ones ? '0 : seed_dat_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [DSIZE-1:0] RAW_SEED = DSIZE'(SEED + 32'(c));
    localparam logic [DSIZE-1:0] CH_SEED  = (RAW_SEED == '1) ? '0 : RAW_SEED;

    lfsr_chan #(
      .DSIZE    (DSIZE),
      .STEPS    (STEPS),
      .WARMUP   (WARMUP),
      .RST_SEED (CH_SEED)
    ) u_chan (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .adv_i      (rd_rand_i[c]),
      .load_i     (seed_hit && (seed_ch_i == CHW'(c))),
      .load_dat_i (seed_clean),
      .dat_o      (lfsr_dat_o[c*DSIZE +: DSIZE]),
      .vld_o      (lfsr_vld_o[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seed_err_q <= 1'b0;
    end else begin
      seed_err_q <= seed_hit && seed_ones;
    end
  end

  assign seed_err_o = seed_err_q;

endmodule

// File: tb/tb_lfsr_bank.sv
module tb_lfsr_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: DSIZE=4, NUM_CH=2, SEED=2, STEPS=1, WARMUP=0 (directed)
  logic       a_rst, a_we, a_err;
  logic [1:0] a_rd, a_vld;
  logic [0:0] a_ch;
  logic [3:0] a_dat;
  logic [7:0] a_out;

  lfsr_bank #(.DSIZE(4), .NUM_CH(2), .STEPS(1), .SEED(2), .WARMUP(0)) u_a (
    .clk_i(clk), .reset_i(a_rst), .rd_rand_i(a_rd), .seed_we_i(a_we),
    .seed_ch_i(a_ch), .seed_dat_i(a_dat), .lfsr_dat_o(a_out),
    .lfsr_vld_o(a_vld), .seed_err_o(a_err)
  );

  // Instance B: DSIZE=16, NUM_CH=3, SEED=0xFFFE, STEPS=3, WARMUP=5 (random)
  logic        b_rst, b_we, b_err;
  logic [2:0]  b_rd, b_vld;
  logic [1:0]  b_ch;
  logic [15:0] b_dat;
  logic [47:0] b_out;

  lfsr_bank #(.DSIZE(16), .NUM_CH(3), .STEPS(3), .SEED(32'hFFFE), .WARMUP(5)) u_b (
    .clk_i(clk), .reset_i(b_rst), .rd_rand_i(b_rd), .seed_we_i(b_we),
    .seed_ch_i(b_ch), .seed_dat_i(b_dat), .lfsr_dat_o(b_out),
    .lfsr_vld_o(b_vld), .seed_err_o(b_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One Fibonacci shift: feedback is the XNOR of an even number of taps,
  // i.e. the inverted parity of the tap bits.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input int w);
    int          t[4];
    logic        par;
    logic [31:0] mask;
    case (w)
      4:       t = '{4, 3, 0, 0};
      16:      t = '{16, 15, 13, 4};
      default: t = '{0, 0, 0, 0};
    endcase
    par = 1'b0;
    foreach (t[k]) if (t[k] != 0) par = par ^ s[t[k]-1];
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return ((s << 1) | {31'b0, ~par}) & mask;
  endfunction

  function automatic logic [31:0] ref_adv(input logic [31:0] s, input int w, input int steps);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < steps; i++) r = ref_step(r, w);
    return r;
  endfunction

  function automatic logic [15:0] b_rseed(input int c);
    logic [31:0] v;
    v = (32'hFFFE + 32'(c)) & 32'hFFFF;
    return (v == 32'hFFFF) ? 16'h0 : v[15:0];
  endfunction

  // Behavioural model of instance B: value, remaining warm advances, error.
  logic [15:0] m_val[3];
  int          m_left[3];
  logic        m_err;
  logic        b_chk_en = 1'b0;

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (b_rst) begin
        m_val[c]  <= b_rseed(c);
        m_left[c] <= 5;
      end else if (b_we && 32'(b_ch) == c) begin
        m_val[c]  <= (b_dat == 16'hFFFF) ? 16'h0 : b_dat;
        m_left[c] <= 5;
      end else if (m_left[c] > 0) begin
        m_val[c]  <= ref_adv(32'(m_val[c]), 16, 3) & 32'hFFFF;
        m_left[c] <= m_left[c] - 1;
      end else if (b_rd[c]) begin
        m_val[c]  <= ref_adv(32'(m_val[c]), 16, 3) & 32'hFFFF;
      end
    end
    m_err <= !b_rst && b_we && (b_ch < 2'd3) && (b_dat == 16'hFFFF);
  end

  always @(negedge clk) begin
    if (b_chk_en) begin
      for (int c = 0; c < 3; c++) begin
        check($sformatf("b_dat%0d", c), 32'(b_out[c*16 +: 16]), 32'(m_val[c]));
        check($sformatf("b_vld%0d", c), 32'(b_vld[c]), 32'(m_left[c] == 0));
      end
      check("b_err", 32'(b_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] seen;
    logic [31:0] s;
    logic        ok;
    logic [3:0]  v;
    logic [3:0]  exp0[3];
    exp0 = '{4'h5, 4'hA, 4'h4};

    a_rst = 1'b1; a_rd = '0; a_we = 1'b0; a_ch = '0; a_dat = '0;
    b_rst = 1'b1; b_rd = '0; b_we = 1'b0; b_ch = '0; b_dat = '0;

    // Hand-computed values pinning the reference step function
    check("model_4b_2_to_5", ref_adv(32'h2, 4, 1), 32'h5);
    check("model_4b_3_to_7", ref_adv(32'h3, 4, 1), 32'h7);
    check("model_leap2", ref_adv(32'h2, 4, 2), 32'hA);
    check("model_warm3", ref_adv(32'h2, 4, 3), 32'h4);
    check("model_16b_fffe", ref_adv(32'hFFFE, 16, 1), 32'hFFFD);
    s = 32'h2; seen = '0; ok = 1'b1;
    for (int k = 0; k < 15; k++) begin
      s = ref_adv(s, 4, 1);
      if (s[3:0] == 4'hF || seen[s[3:0]]) ok = 1'b0;
      seen[s[3:0]] = 1'b1;
    end
    check("model_period_distinct", 32'(ok), 32'h1);
    check("model_period_return", s, 32'h2);

    cyc();
    b_chk_en = 1'b1;

    // A: reset state
    check("a_rst_ch0", 32'(a_out[3:0]), 32'h2);
    check("a_rst_ch1", 32'(a_out[7:4]), 32'h3);
    check("a_rst_vld", 32'(a_vld), 32'h3);
    check("a_rst_err", 32'(a_err), 32'h0);
    a_rst = 1'b0;

    // A: ch0 advances three times, ch1 holds; outputs stable when idle
    for (int i = 0; i < 3; i++) begin
      a_rd = 2'b01; cyc();
      check("a_seq_ch0", 32'(a_out[3:0]), 32'(exp0[i]));
      check("a_seq_ch1_hold", 32'(a_out[7:4]), 32'h3);
      a_rd = 2'b00; cyc();
      check("a_idle_ch0", 32'(a_out[3:0]), 32'(exp0[i]));
    end
    a_rd = 2'b10; cyc();
    check("a_ch1_first", 32'(a_out[7:4]), 32'h7);
    cyc();
    check("a_ch1_second", 32'(a_out[7:4]), 32'hE);
    check("a_ch0_hold", 32'(a_out[3:0]), 32'h4);
    a_rd = 2'b00;

    // A: full period from reset
    a_rst = 1'b1; cyc(); a_rst = 1'b0;
    seen = '0;
    for (int k = 0; k < 15; k++) begin
      a_rd = 2'b01; cyc();
      v = a_out[3:0];
      check("a_period_unique", 32'(v != 4'hF && !seen[v]), 32'h1);
      seen[v] = 1'b1;
    end
    check("a_period_return", 32'(a_out[3:0]), 32'h2);
    a_rd = 2'b00;

    // A: all-ones seed replaced, concurrent advance request ignored
    a_we = 1'b1; a_ch = 1'b1; a_dat = 4'hF; a_rd = 2'b10; cyc();
    check("a_seedF_ch1", 32'(a_out[7:4]), 32'h0);
    check("a_seedF_err", 32'(a_err), 32'h1);
    check("a_seedF_ch0", 32'(a_out[3:0]), 32'h2);
    a_we = 1'b0; a_rd = 2'b00; cyc();
    check("a_err_pulse_end", 32'(a_err), 32'h0);
    a_we = 1'b1; a_ch = 1'b1; a_dat = 4'h9; a_rd = 2'b11; cyc();
    check("a_seed_beats_rd", 32'(a_out[7:4]), 32'h9);
    check("a_other_ch_adv", 32'(a_out[3:0]), 32'h5);
    check("a_good_seed_err", 32'(a_err), 32'h0);
    a_we = 1'b0; a_rd = 2'b00;

    // B: reset release, reset again at warm cycle 4, full warm-up restarts
    b_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_rd = 3'($urandom); cyc();
    end
    b_rst = 1'b1; cyc();
    check("b_midrst_vld", 32'(b_vld), 32'h0);
    check("b_midrst_ch0", 32'(b_out[15:0]), 32'hFFFE);
    check("b_midrst_ch1", 32'(b_out[31:16]), 32'h0);
    check("b_midrst_ch2", 32'(b_out[47:32]), 32'h0);
    b_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_rd = 3'($urandom); cyc();
      check("b_warm_vld", 32'(b_vld), (i == 4) ? 32'h7 : 32'h0);
    end

    // B: back-to-back rejected seeds, then an out-of-range write
    b_we = 1'b1; b_ch = 2'd0; b_dat = 16'hFFFF; cyc();
    check("b_err_1", 32'(b_err), 32'h1);
    check("b_seedF_ch0", 32'(b_out[15:0]), 32'h0);
    b_ch = 2'd2; cyc();
    check("b_err_2", 32'(b_err), 32'h1);
    b_ch = 2'd3; cyc();
    check("b_oob_no_err", 32'(b_err), 32'h0);
    b_we = 1'b0; cyc();

    // B: random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      b_rd  = 3'($urandom);
      b_we  = ($urandom_range(0, 7) == 0);
      b_ch  = 2'($urandom_range(0, 3));
      b_dat = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b_rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) b_rd = '0;
      cyc();
    end
    b_rst = 1'b0; b_we = 1'b0; b_rd = '0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_bank.md
# lfsr_bank

Bank of NUM_CH independent XNOR Fibonacci LFSRs, 4 to 32 bits wide, producing per-channel pseudo-random words for stochastic neuron and synapse logic. It extends our single-channel generator with four additions: runtime seed loading, multi-bit leap-forward per advance, protection against the all-ones lock-up state, and a per-channel warm-up state machine. The warm-up decorrelates channels before their outputs are flagged valid. The block sits beside the neuron array and feeds one channel per consumer.

## Interface
- DSIZE, 16, LFSR width per channel; legal range 4..32.
- NUM_CH, 4, number of channels; legal range ≥1.
- STEPS, 1, single-bit shifts applied per advance; legal range 1..DSIZE.
- SEED, 2, base reset seed.
- WARMUP, 8, self-advances after reset or seed load before valid asserts; 0 is legal.
- clk_i  in  1  single clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- rd_rand_i  in  NUM_CH  per-channel advance request.
- seed_we_i  in  1  seed write strobe.
- seed_ch_i  in  CHW  target channel; CHW = max(1, clog2(NUM_CH)).
- seed_dat_i  in  DSIZE  seed value.
- lfsr_dat_o  out  NUM_CH*DSIZE  channel c occupies bits [c*DSIZE +: DSIZE]; registered.
- lfsr_vld_o  out  NUM_CH  channel is in RUN.
- seed_err_o  out  1  one-cycle pulse: the rejected all-ones seed was replaced.

## Operation
- **Step function:** shift left; the feedback bit enters at bit 0. Feedback is the XNOR of the XAPP052 taps. Bits are numbered 1..DSIZE in the tap list:
  - 4: 4,3
  - 8: 8,6,5,4
  - 16: 16,15,13,4
  - 32: 32,22,2,1
  - Other widths take their entries from the same table.
- **Advance:** one advance applies the step function STEPS times, combinationally.
- **Reset seed:** channel c resets to (SEED + c) mod 2^DSIZE. If that value is all-ones, the channel resets to 0 instead.
- **Per-channel FSM, WARM state:**
  - lfsr_vld_o=0 and rd_rand_i is ignored.
  - The channel advances every cycle and decrements warm_cnt.
  - When warm_cnt reaches 0, the channel goes to RUN.
- **Per-channel FSM, RUN state:**
  - lfsr_vld_o=1.
  - The channel advances on each cycle its rd_rand_i bit is 1 and holds otherwise.
- **Reset:** every channel goes to WARM (RUN if WARMUP=0), warm_cnt=WARMUP, state=reset seed, seed_err_o=0.
- **Seed write** (seed_we_i=1 and seed_ch_i < NUM_CH):
  - The target state is loaded with seed_dat_i.
  - The target goes to WARM with warm_cnt=WARMUP (RUN if WARMUP=0).
  - If seed_dat_i is all-ones, 0 is loaded instead and seed_err_o pulses the next cycle.
- **Out-of-range seed_ch_i:** the write is ignored with no error pulse.
- **Simultaneous events:**
  - A seed write beats rd_rand_i and the warm advance on the same channel.
  - Other channels are unaffected.
- **Reset precedence:** reset_i beats everything. Reset asserted mid-warm-up or mid-run restores reset values on the next edge.
- **Period:** each channel has period 2^DSIZE−1 advances (STEPS=1). The all-ones state is unreachable.

## Timing
- **Output latency:** an advance or seed load is visible on lfsr_dat_o one cycle after the qualifying edge. There is no combinational path from inputs to outputs.
- **Warm-up duration:** lfsr_vld_o rises exactly WARMUP rising edges after the first edge with reset_i=0, or after the seed-write edge.
- **Output in WARM:** lfsr_dat_o changes every cycle during WARM.
- **Output in RUN:** lfsr_dat_o is stable while rd_rand_i=0.
- **seed_err_o:** high for exactly one cycle per rejected seed. Back-to-back rejected writes produce back-to-back pulses.

## Structure
- **Shared include/package `lfsr_pkg`:**
  - tap-mask function lfsr_taps(DSIZE), returning a 32-bit mask;
  - FSM state encoding (WARM=0, RUN=1);
  - CHW derivation.
- **Sub-module `lfsr_chan`:** one channel containing the state register, the STEPS-unrolled step function, the warm counter and the FSM. It is parameterised with DSIZE, STEPS, WARMUP and its reset seed.
- **Top `lfsr_bank`:**
  - a generate loop over channels;
  - seed-write decode;
  - the seed_err_o register.

## Test plan
- **Reset and basic sequence.** Config: DSIZE=4, NUM_CH=2, SEED=2, WARMUP=0, STEPS=1.
  - After reset, ch0=0x2, ch1=0x3 and both lfsr_vld_o=1.
  - Pulse rd_rand_i[0] three times: ch0 reads 0x5, 0xA, 0x4 and ch1 holds 0x3.
  - Pulse rd_rand_i[1] twice: ch1 reads 0x7, 0xE.
- **Full period.** Same config: 15 advances on ch0 return it to 0x2. All 15 non-0xF values appear once and 0xF never appears.
- **Leap-forward.** STEPS=2: one advance takes ch0 from 0x2 to 0xA.
- **Warm-up.** WARMUP=3:
  - lfsr_vld_o is low for 3 cycles after reset release, then high.
  - ch0 reads 0x4 when valid rises, with rd_rand_i held at 0 throughout.
- **Seed handling.**
  - Writing seed 0xF to ch1 loads 0x0 and gives one seed_err_o pulse.
  - seed_ch_i=2 with NUM_CH=2 changes nothing.
  - A seed write with rd_rand_i[1]=1 in the same cycle loads the seed without advancing it.
- **Reset mid-warm-up.** WARMUP=8: assert reset_i at warm cycle 4. All channels return to reset seeds with lfsr_vld_o=0, and the warm-up restarts with its full count.
